word_serializer: RTL

- Parallel-to-serial stage directly upstream of the running-parity block.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per paced step on serial_bit, LSB first.
- Emits word_start/word_end framing so the downstream stage can clear or sample its parity per word.
- Carries a free-running count of completed words for debug.

---
 rtl/word_serializer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/word_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words over valid/ready and shifts them out LSB first
// with word_start/word_end framing. Define WORD_SERIALIZER_PARITY_APPEND_EN to append an even-parity bit.
module word_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             bit_enable,
  output logic             serial_bit,
  output logic             bit_valid,
  output logic             word_start,
  output logic             word_end,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   shift_r, shift_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic               par_r, par_s;
  logic               done_s;
  logic               serial_bit_s, bit_valid_s, word_start_s, word_end_s;

  // State, datapath and registered-output storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      shift_r    <= {WIDTH{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      par_r      <= 1'b0;
      serial_bit <= 1'b0;
      bit_valid  <= 1'b0;
      word_start <= 1'b0;
      word_end   <= 1'b0;
      busy       <= 1'b0;
      word_count <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      idx_r      <= idx_s;
      par_r      <= par_s;
      serial_bit <= serial_bit_s;
      bit_valid  <= bit_valid_s;
      word_start <= word_start_s;
      word_end   <= word_end_s;
      busy       <= bit_valid_s;
      if (done_s) begin
        word_count <= word_count + CNT_W'(1);
      end else begin
        word_count <= word_count;
      end
    end
  end

  // Next-state logic; done_s marks consumption of the final step of a word
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    idx_s   = idx_r;
    par_s   = par_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (data_valid) begin
          state_s = ST_SHIFT;
          shift_s = data_in;
          idx_s   = {IDX_W{1'b0}};
          par_s   = even_parity(data_in);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!bit_enable) begin
          state_s = ST_SHIFT;
        end else if (idx_r != LAST_IDX) begin
          shift_s = shift_r >> 1;
          idx_s   = idx_r + IDX_W'(1);
        end else begin
`ifdef WORD_SERIALIZER_PARITY_APPEND_EN
          state_s = ST_PARITY;
          idx_s   = IDX_W'(WIDTH);
`else
          done_s  = 1'b1;
`endif
        end
      end
      ST_PARITY: begin
`ifdef WORD_SERIALIZER_PARITY_APPEND_EN
        if (bit_enable) begin
          done_s = 1'b1;
        end else begin
          state_s = ST_PARITY;
        end
`else
        state_s = ST_IDLE;
`endif
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Word finished: chain straight into the next word when one is waiting
    if (done_s) begin
      if (data_valid) begin
        state_s = ST_SHIFT;
        shift_s = data_in;
        idx_s   = {IDX_W{1'b0}};
        par_s   = even_parity(data_in);
      end else begin
        state_s = ST_IDLE;
        shift_s = {WIDTH{1'b0}};
        idx_s   = {IDX_W{1'b0}};
        par_s   = 1'b0;
      end
    end else begin
      par_s = par_s;
    end
  end

  // Ready is combinational so a waiting word can be taken on the last paced step
  always_comb begin
    if (state_r == ST_IDLE) begin
      data_ready = 1'b1;
    end else begin
      data_ready = done_s;
    end
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    serial_bit_s = 1'b0;
    bit_valid_s  = 1'b0;
    word_start_s = 1'b0;
    word_end_s   = 1'b0;
    case (state_s)
      ST_SHIFT: begin
        serial_bit_s = shift_s[0];
        bit_valid_s  = 1'b1;
        word_start_s = (idx_s == {IDX_W{1'b0}});
`ifdef WORD_SERIALIZER_PARITY_APPEND_EN
        word_end_s   = 1'b0;
`else
        word_end_s   = (idx_s == LAST_IDX);
`endif
      end
      ST_PARITY: begin
        serial_bit_s = par_s;
        bit_valid_s  = 1'b1;
        word_start_s = 1'b0;
        word_end_s   = 1'b1;
      end
      default: begin
        serial_bit_s = 1'b0;
        bit_valid_s  = 1'b0;
        word_start_s = 1'b0;
        word_end_s   = 1'b0;
      end
    endcase
  end

endmodule
